// File: rtl/bullet_engine.sv
// Per-frame projectile engine: on each new-frame strobe it moves live bullets, retires off-screen
// ones, scans every bullet/opponent pair for hits and spawns requested shots under a cooldown.
module bullet_engine #(
    parameter int unsigned N_PLAYERS          = 3,
    parameter int unsigned BULLETS_PER_PLAYER = 2,
    parameter int unsigned BOX_DIM            = 90,
    parameter int unsigned SPEED              = 15,
    parameter int unsigned X_MIN              = 17,
    parameter int unsigned X_MAX              = 1260,
    parameter int unsigned Y_MIN              = 17,
    parameter int unsigned Y_MAX              = 700,
    parameter int unsigned COOLDOWN           = 8,
    localparam int unsigned NumSlots = N_PLAYERS * BULLETS_PER_PLAYER,
    localparam int unsigned PlyW     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     nf_in,
    input  logic [N_PLAYERS-1:0]     fire_in,
    input  logic [3*N_PLAYERS-1:0]   fire_dir_in,
    input  logic [11*N_PLAYERS-1:0]  box_x_in,
    input  logic [10*N_PLAYERS-1:0]  box_y_in,
    output logic [NumSlots-1:0]      bullet_active_out,
    output logic [11*NumSlots-1:0]   bullet_x_out,
    output logic [10*NumSlots-1:0]   bullet_y_out,
    output logic                     hit_valid_out,
    output logic [PlyW-1:0]          hit_shooter_out,
    output logic [PlyW-1:0]          hit_victim_out,
    output logic                     busy_out,
    output logic                     frame_drop_out
);

    localparam int unsigned SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned CdW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [2:0] DirRight = 3'd1;
    localparam logic [2:0] DirLeft  = 3'd2;
    localparam logic [2:0] DirUp    = 3'd3;
    localparam logic [2:0] DirDown  = 3'd4;

    typedef enum logic [1:0] {StIdle, StMove, StScan, StSpawn} state_e;

    state_e                         state_q;
    logic [NumSlots-1:0]            active_q;
    logic [NumSlots-1:0][10:0]      x_q;
    logic [NumSlots-1:0][9:0]       y_q;
    logic [NumSlots-1:0][2:0]       dir_q;
    logic [N_PLAYERS-1:0][CdW-1:0]  cd_q;
    logic [N_PLAYERS-1:0]           pend_q;
    logic [N_PLAYERS-1:0][2:0]      pdir_q;
    logic [SlotW-1:0]               scan_s_q;
    logic [PlyW-1:0]                scan_v_q;

    assign bullet_active_out = active_q;
    assign bullet_x_out      = x_q;
    assign bullet_y_out      = y_q;

    // Movement results, applied in the single MOVE cycle.
    logic [NumSlots-1:0]       mv_active;
    logic [NumSlots-1:0][10:0] mv_x;
    logic [NumSlots-1:0][9:0]  mv_y;

    always_comb begin
        mv_active = active_q;
        mv_x      = x_q;
        mv_y      = y_q;
        for (int s = 0; s < int'(NumSlots); s++) begin
            if (active_q[s]) begin
                case (dir_q[s])
                    DirRight: begin
                        if ({1'b0, x_q[s]} + 12'(SPEED) > 12'(X_MAX)) mv_active[s] = 1'b0;
                        else mv_x[s] = x_q[s] + 11'(SPEED);
                    end
                    DirLeft: begin
                        if ({1'b0, x_q[s]} < 12'(X_MIN + SPEED)) mv_active[s] = 1'b0;
                        else mv_x[s] = x_q[s] - 11'(SPEED);
                    end
                    DirUp: begin
                        if ({2'b0, y_q[s]} < 12'(Y_MIN + SPEED)) mv_active[s] = 1'b0;
                        else mv_y[s] = y_q[s] - 10'(SPEED);
                    end
                    DirDown: begin
                        if ({2'b0, y_q[s]} + 12'(SPEED) > 12'(Y_MAX)) mv_active[s] = 1'b0;
                        else mv_y[s] = y_q[s] + 10'(SPEED);
                    end
                    default: mv_active[s] = 1'b0;
                endcase
            end
        end
    end

    // Collision test for the pair currently visited by the scan counter.
    logic [PlyW-1:0] scan_owner;
    logic [11:0]     scan_bx, scan_by, scan_px, scan_py;
    logic            scan_hit;

    always_comb begin
        scan_owner = '0;
        for (int s = 0; s < int'(NumSlots); s++) begin
            if (scan_s_q == SlotW'(s)) scan_owner = PlyW'(s / int'(BULLETS_PER_PLAYER));
        end
        scan_bx  = {1'b0, x_q[scan_s_q]};
        scan_by  = {2'b0, y_q[scan_s_q]};
        scan_px  = {1'b0, box_x_in[11*scan_v_q +: 11]};
        scan_py  = {2'b0, box_y_in[10*scan_v_q +: 10]};
        scan_hit = active_q[scan_s_q] && (scan_v_q != scan_owner) &&
                   (scan_px < scan_bx) && (scan_bx < scan_px + 12'(BOX_DIM)) &&
                   (scan_py < scan_by) && (scan_by < scan_py + 12'(BOX_DIM));
    end

    // Lowest free slot per player; the descending loop lets the lowest index win.
    logic [N_PLAYERS-1:0]            spawn_ok;
    logic [N_PLAYERS-1:0][SlotW-1:0] spawn_slot;
    logic [N_PLAYERS-1:0]            fire_ok;

    always_comb begin
        for (int p = 0; p < int'(N_PLAYERS); p++) begin
            spawn_ok[p]   = 1'b0;
            spawn_slot[p] = '0;
            for (int b = int'(BULLETS_PER_PLAYER) - 1; b >= 0; b--) begin
                if (!active_q[p*int'(BULLETS_PER_PLAYER) + b]) begin
                    spawn_ok[p]   = 1'b1;
                    spawn_slot[p] = SlotW'(p*int'(BULLETS_PER_PLAYER) + b);
                end
            end
            fire_ok[p] = fire_in[p] && (fire_dir_in[3*p +: 3] != 3'd0) &&
                         (fire_dir_in[3*p +: 3] <= DirDown);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= StIdle;
            active_q        <= '0;
            x_q             <= '0;
            y_q             <= '0;
            dir_q           <= '0;
            cd_q            <= '0;
            pend_q          <= '0;
            pdir_q          <= '0;
            scan_s_q        <= '0;
            scan_v_q        <= '0;
            busy_out        <= 1'b0;
            frame_drop_out  <= 1'b0;
            hit_valid_out   <= 1'b0;
            hit_shooter_out <= '0;
            hit_victim_out  <= '0;
        end else begin
            hit_valid_out  <= 1'b0;
            frame_drop_out <= nf_in && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (nf_in) begin
                        state_q  <= StMove;
                        busy_out <= 1'b1;
                    end
                end
                StMove: begin
                    active_q <= mv_active;
                    x_q      <= mv_x;
                    y_q      <= mv_y;
                    scan_s_q <= '0;
                    scan_v_q <= '0;
                    state_q  <= StScan;
                end
                StScan: begin
                    if (scan_hit) begin
                        active_q[scan_s_q] <= 1'b0;
                        hit_valid_out      <= 1'b1;
                        hit_shooter_out    <= scan_owner;
                        hit_victim_out     <= scan_v_q;
                    end
                    if (scan_v_q == PlyW'(N_PLAYERS - 1)) begin
                        scan_v_q <= '0;
                        if (scan_s_q == SlotW'(NumSlots - 1)) state_q <= StSpawn;
                        else scan_s_q <= scan_s_q + SlotW'(1);
                    end else begin
                        scan_v_q <= scan_v_q + PlyW'(1);
                    end
                end
                StSpawn: begin
                    for (int p = 0; p < int'(N_PLAYERS); p++) begin
                        if (cd_q[p] != '0) begin
                            cd_q[p] <= cd_q[p] - CdW'(1);
                        end else if (pend_q[p] && spawn_ok[p]) begin
                            active_q[spawn_slot[p]] <= 1'b1;
                            x_q[spawn_slot[p]]      <= box_x_in[11*p +: 11] + 11'(BOX_DIM / 2);
                            y_q[spawn_slot[p]]      <= box_y_in[10*p +: 10] + 10'(BOX_DIM / 2);
                            dir_q[spawn_slot[p]]    <= pdir_q[p];
                            cd_q[p]                 <= CdW'(COOLDOWN);
                        end
                    end
                    pend_q   <= '0;
                    busy_out <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // Placed after the case so a request arriving in the SPAWN cycle survives the clear.
            for (int p = 0; p < int'(N_PLAYERS); p++) begin
                if (fire_ok[p]) begin
                    pend_q[p] <= 1'b1;
                    pdir_q[p] <= fire_dir_in[3*p +: 3];
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Randomised and directed checks of bullet_engine against a frame-level reference model.
module tb_bullet_engine;
    localparam int P = 3;
    localparam int B = 2;
    localparam int S = P * B;
    localparam int FrameCycles = S * P + 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          nf_in;
    logic [P-1:0]  fire_in;
    logic [3*P-1:0]  fire_dir_in;
    logic [11*P-1:0] box_x_in;
    logic [10*P-1:0] box_y_in;
    logic [S-1:0]    bullet_active_out;
    logic [11*S-1:0] bullet_x_out;
    logic [10*S-1:0] bullet_y_out;
    logic            hit_valid_out;
    logic [1:0]      hit_shooter_out;
    logic [1:0]      hit_victim_out;
    logic            busy_out;
    logic            frame_drop_out;

    bullet_engine dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .nf_in             (nf_in),
        .fire_in           (fire_in),
        .fire_dir_in       (fire_dir_in),
        .box_x_in          (box_x_in),
        .box_y_in          (box_y_in),
        .bullet_active_out (bullet_active_out),
        .bullet_x_out      (bullet_x_out),
        .bullet_y_out      (bullet_y_out),
        .hit_valid_out     (hit_valid_out),
        .hit_shooter_out   (hit_shooter_out),
        .hit_victim_out    (hit_victim_out),
        .busy_out          (busy_out),
        .frame_drop_out    (frame_drop_out)
    );

    always #5 clk_in = ~clk_in;

    int m_act[S], m_x[S], m_y[S], m_dir[S];
    int m_cd[P], m_pend[P], m_pdir[P];
    int bx[P], by[P];
    int exp_hits[$];
    int n_checks = 0;
    int n_pass = 0;
    int hits_seen = 0;
    int last_hit = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_boxes;
        for (int p = 0; p < P; p++) begin
            box_x_in[11*p +: 11] = 11'(bx[p]);
            box_y_in[10*p +: 10] = 10'(by[p]);
        end
    endtask

    task automatic model_reset;
        for (int s = 0; s < S; s++) begin
            m_act[s] = 0; m_x[s] = 0; m_y[s] = 0; m_dir[s] = 0;
        end
        for (int p = 0; p < P; p++) begin
            m_cd[p] = 0; m_pend[p] = 0; m_pdir[p] = 0;
        end
    endtask

    task automatic do_reset;
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic fire(input int p, input int d);
        fire_in = '0;
        fire_in[p] = 1'b1;
        fire_dir_in[3*p +: 3] = 3'(d);
        tick();
        fire_in = '0;
        if (d >= 1 && d <= 4) begin
            m_pend[p] = 1;
            m_pdir[p] = d;
        end
    endtask

    // Whole-frame reference: move, scan in slot-major order, then spawn.
    task automatic model_frame;
        exp_hits.delete();
        for (int s = 0; s < S; s++) begin
            if (m_act[s] != 0) begin
                case (m_dir[s])
                    1: if (m_x[s] + 15 > 1260) m_act[s] = 0; else m_x[s] += 15;
                    2: if (m_x[s] < 32) m_act[s] = 0; else m_x[s] -= 15;
                    3: if (m_y[s] < 32) m_act[s] = 0; else m_y[s] -= 15;
                    default: if (m_y[s] + 15 > 700) m_act[s] = 0; else m_y[s] += 15;
                endcase
            end
        end
        for (int s = 0; s < S; s++) begin
            for (int v = 0; v < P; v++) begin
                if (m_act[s] != 0 && v != s / B && bx[v] < m_x[s] && m_x[s] < bx[v] + 90 &&
                    by[v] < m_y[s] && m_y[s] < by[v] + 90) begin
                    m_act[s] = 0;
                    exp_hits.push_back(((2 + s*P + v) << 8) | ((s / B) << 4) | v);
                end
            end
        end
        for (int p = 0; p < P; p++) begin
            if (m_cd[p] != 0) begin
                m_cd[p]--;
            end else if (m_pend[p] != 0) begin
                for (int b = 0; b < B; b++) begin
                    if (m_act[p*B + b] == 0) begin
                        m_act[p*B + b] = 1;
                        m_x[p*B + b]   = (bx[p] + 45) & 'h7ff;
                        m_y[p*B + b]   = (by[p] + 45) & 'h3ff;
                        m_dir[p*B + b] = m_pdir[p];
                        m_cd[p]        = 8;
                        break;
                    end
                end
            end
            m_pend[p] = 0;
        end
    endtask

    // drop_at >= 2 pulses nf_in once in the middle of the scan.
    task automatic run_frame(input int drop_at);
        int got_hits[$];
        int n;
        model_frame();
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        check("busy_start", busy_out, 1);
        for (int k = 1; k <= FrameCycles; k++) begin
            tick();
            if (hit_valid_out) begin
                got_hits.push_back((k << 8) | (int'(hit_shooter_out) << 4) | int'(hit_victim_out));
            end
            if (drop_at >= 2 && k == drop_at + 1) begin
                nf_in = 1'b0;
                check("frame_drop", frame_drop_out, 1);
            end
            if (drop_at >= 2 && k == drop_at + 2) check("frame_drop_end", frame_drop_out, 0);
            if (drop_at >= 2 && k == drop_at) nf_in = 1'b1;
            if (k == FrameCycles - 1) check("busy_last", busy_out, 1);
        end
        check("busy_done", busy_out, 0);
        hits_seen += got_hits.size();
        check("hit_count", got_hits.size(), exp_hits.size());
        n = (got_hits.size() < exp_hits.size()) ? got_hits.size() : exp_hits.size();
        for (int i = 0; i < n; i++) check("hit_info", got_hits[i], exp_hits[i]);
        if (got_hits.size() > 0) last_hit = got_hits[got_hits.size() - 1] & 'hff;
        for (int s = 0; s < S; s++) begin
            check($sformatf("active%0d", s), int'(bullet_active_out[s]), m_act[s]);
            check($sformatf("x%0d", s), int'(bullet_x_out[11*s +: 11]), m_x[s]);
            check($sformatf("y%0d", s), int'(bullet_y_out[10*s +: 10]), m_y[s]);
        end
    endtask

    task automatic set_far_boxes;
        bx[0] = 100;  by[0] = 100;
        bx[1] = 1000; by[1] = 600;
        bx[2] = 600;  by[2] = 600;
        drive_boxes();
    endtask

    task automatic random_frames(input int frames, input int xlo, input int xhi,
                                 input int ylo, input int yhi);
        for (int f = 0; f < frames; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int p = 0; p < P; p++) begin
                    bx[p] = $urandom_range(xlo, xhi);
                    by[p] = $urandom_range(ylo, yhi);
                end
                drive_boxes();
            end
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 1) == 1) fire(p, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) run_frame($urandom_range(2, 17));
            else run_frame(-1);
        end
    endtask

    initial begin
        int h0;
        int cnt;
        rst_n_in    = 1'b0;
        nf_in       = 1'b0;
        fire_in     = '0;
        fire_dir_in = '0;
        box_x_in    = '0;
        box_y_in    = '0;
        model_reset();
        tick();
        tick();
        check("rst_busy", busy_out, 0);
        check("rst_active", int'(bullet_active_out), 0);
        check("rst_hit", hit_valid_out, 0);
        check("rst_drop", frame_drop_out, 0);
        check("rst_x", int'(bullet_x_out[31:0]), 0);
        rst_n_in = 1'b1;
        tick();

        // Straight shot, frame drop mid-scan, then flight to the right edge.
        set_far_boxes();
        fire(0, 1);
        run_frame(-1);
        check("t2_spawn_x", int'(bullet_x_out[10:0]), 145);
        check("t2_spawn_y", int'(bullet_y_out[9:0]), 145);
        run_frame(-1);
        run_frame(5);
        run_frame(-1);
        check("t2_x_after3", int'(bullet_x_out[10:0]), 190);
        for (int f = 0; f < 100 && m_act[0] != 0; f++) run_frame(-1);
        check("t2_retired", int'(bullet_active_out[0]), 0);

        // Single hit on P1.
        do_reset();
        bx[0] = 100; by[0] = 100; bx[1] = 300; by[1] = 100; bx[2] = 600; by[2] = 600;
        drive_boxes();
        fire(0, 1);
        h0 = hits_seen;
        for (int f = 0; f < 14; f++) run_frame(-1);
        check("t3_hits", hits_seen - h0, 1);
        check("t3_attrib", last_hit, (0 << 4) | 1);
        check("t3_slot_dead", int'(bullet_active_out[0]), 0);

        // Cooldown and full-magazine drop.
        do_reset();
        set_far_boxes();
        for (int f = 1; f <= 20; f++) begin
            fire(0, 1);
            run_frame(-1);
            cnt = int'(bullet_active_out[0]) + int'(bullet_active_out[1]);
            if (f == 1) check("t4_f1", cnt, 1);
            if (f == 9) check("t4_f9", cnt, 1);
            if (f == 10) check("t4_f10", cnt, 2);
            if (f == 20) check("t4_f20", cnt, 2);
        end

        // Invalid directions, then a shot that starts inside its own box.
        do_reset();
        set_far_boxes();
        fire(0, 0);
        fire(0, 5);
        fire(0, 7);
        run_frame(-1);
        check("t6_invalid", int'(bullet_active_out), 0);
        fire(0, 3);
        h0 = hits_seen;
        run_frame(-1);
        run_frame(-1);
        check("t6_no_self", hits_seen - h0, 0);
        check("t6_alive", int'(bullet_active_out[0]), 1);

        // Random play: crowded boxes for hits, then the whole field for edge retirement.
        random_frames(60, 80, 400, 80, 300);
        random_frames(100, 17, 1170, 17, 610);

        // Reset in the middle of a scan.
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        tick();
        tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        check("midrst_active", int'(bullet_active_out), 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_hit", hit_valid_out, 0);
        tick();
        rst_n_in = 1'b1;
        model_reset();
        tick();
        set_far_boxes();
        fire(0, 4);
        run_frame(-1);
        run_frame(-1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
